// File: rtl/icache_refill_pkg.sv
// rtl/icache_refill_pkg.sv - shared RAM/line geometry for icache, refill engine and RAM arbiter
package icache_refill_pkg;

    // Byte-address width of the RAM space.
    localparam int ADDR_WIDTH       = 17;
    // log2 of the cache line size in bytes.
    localparam int BLOCK_WIDTH      = 4;
    // Line size in bytes; always derived, never set independently.
    localparam int BLOCK_SIZE       = 2 ** BLOCK_WIDTH;
    localparam int LINE_WIDTH       = BLOCK_SIZE * 8;
    localparam int TAG_WIDTH        = ADDR_WIDTH - BLOCK_WIDTH;
    // Byte counters must reach BLOCK_SIZE itself, hence one extra bit.
    localparam int CNT_WIDTH        = BLOCK_WIDTH + 1;
    // Cycles from ramAddr to the matching ramDataIn.
    localparam int RAM_READ_LATENCY = 1;

endpackage

// File: rtl/icache_refill_line_buffer.sv
// rtl/icache_refill_line_buffer.sv - byte-lane demux and line register for the refill engine
//
// Purpose: accumulates one cache line a byte at a time.
// Ports:
//   clkIn     in   system clock
//   resetNIn  in   asynchronous reset, active-low; clears the line
//   byteWe    in   write the byte at byteIdx this cycle
//   byteIdx   in   byte lane to write (0 = bits [7:0])
//   byteData  in   byte value to store
//   line      out  assembled line, byte k at [8k+7:8k]
module refill_line_buffer
    import icache_refill_pkg::*;
(
    input  logic                   clkIn,
    input  logic                   resetNIn,
    input  logic                   byteWe,
    input  logic [BLOCK_WIDTH-1:0] byteIdx,
    input  logic [7:0]             byteData,
    output logic [LINE_WIDTH-1:0]  line
);

    always_ff @(posedge clkIn or negedge resetNIn) begin
        if (!resetNIn) begin
            line <= '0;
        end else if (byteWe) begin
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                if (byteIdx == BLOCK_WIDTH'(k)) begin
                    line[8*k +: 8] <= byteData;
                end
            end
        end
    end

endmodule

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - instruction cache miss-service engine (line refill over a byte-wide RAM port)
//
// Purpose: on a miss, wins the shared RAM port, reads the whole line containing the
// missing byte, and presents it to the cache with a single-cycle fillValid strobe.
// Ports:
//   clkIn       in   system clock
//   resetNIn    in   asynchronous reset, active-low
//   missIn      in   miss request (level), only looked at while idle
//   missAddrIn  in   byte address that missed
//   busy        out  engine is servicing a miss
//   ramReq      out  request for the shared RAM port
//   ramGrant    in   arbiter grant, held while ramReq is high
//   ramAddr     out  RAM byte read address (0 when not reading)
//   ramDataIn   in   RAM read data, one cycle after ramAddr
//   fillValid   out  one-cycle line-write strobe
//   fillAddr    out  line address of fillData
//   fillData    out  assembled line, byte k at [8k+7:8k]
module icache_refill
    import icache_refill_pkg::*;
(
    input  logic                  clkIn,
    input  logic                  resetNIn,
    input  logic                  missIn,
    input  logic [ADDR_WIDTH-1:0] missAddrIn,
    output logic                  busy,
    output logic                  ramReq,
    input  logic                  ramGrant,
    output logic [ADDR_WIDTH-1:0] ramAddr,
    input  logic [7:0]            ramDataIn,
    output logic                  fillValid,
    output logic [TAG_WIDTH-1:0]  fillAddr,
    output logic [LINE_WIDTH-1:0] fillData
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_GNT = 2'd1;
    localparam logic [1:0] ST_READ     = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        WAIT_GNT = ST_WAIT_GNT,
        READ     = ST_READ,
        DONE     = ST_DONE
    } state_t;

    state_t                 state;
    state_t                 stateNext;
    logic [TAG_WIDTH-1:0]   lineTag;
    logic [CNT_WIDTH-1:0]   issue;
    logic [CNT_WIDTH-1:0]   recv;
    logic                   byteWe;
    logic                   startRead;
    logic [BLOCK_WIDTH-1:0] readIdx;

    // issue stops at BLOCK_SIZE; its top bit is set only there, and the
    // address then stays parked on the last byte of the line.
    assign readIdx = issue[BLOCK_WIDTH] ? {BLOCK_WIDTH{1'b1}} : issue[BLOCK_WIDTH-1:0];

    always_comb begin
        stateNext = state;
        startRead = 1'b0;
        byteWe    = 1'b0;
        busy      = 1'b1;
        ramReq    = 1'b0;
        ramAddr   = '0;
        fillValid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (missIn) begin
                    stateNext = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                ramReq = 1'b1;
                if (ramGrant) begin
                    startRead = 1'b1;
                    stateNext = READ;
                end
            end
            READ: begin
                ramReq  = 1'b1;
                ramAddr = {lineTag, readIdx};
                // With a one-cycle RAM, data for the first address shows up
                // in the second READ cycle, so capture starts once issue moved.
                byteWe  = (issue != '0);
                if (byteWe && (recv == CNT_WIDTH'(BLOCK_SIZE - 1))) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                fillValid = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkIn or negedge resetNIn) begin
        if (!resetNIn) begin
            state    <= IDLE;
            lineTag  <= '0;
            issue    <= '0;
            recv     <= '0;
            fillAddr <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && missIn) begin
                lineTag <= missAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH];
            end
            if (startRead) begin
                issue <= '0;
                recv  <= '0;
            end else begin
                if (state == READ && !issue[BLOCK_WIDTH]) begin
                    issue <= issue + CNT_WIDTH'(1);
                end
                if (byteWe) begin
                    recv <= recv + CNT_WIDTH'(1);
                end
            end
            // Latched on entry to DONE so it survives the next miss's tag capture.
            if (state == READ && stateNext == DONE) begin
                fillAddr <= lineTag;
            end
        end
    end

    refill_line_buffer uLineBuffer (
        .clkIn    (clkIn),
        .resetNIn (resetNIn),
        .byteWe   (byteWe),
        .byteIdx  (recv[BLOCK_WIDTH-1:0]),
        .byteData (ramDataIn),
        .line     (fillData)
    );

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - self-checking bench for icache_refill
module tb_icache_refill;
    import icache_refill_pkg::*;

    localparam int AW = ADDR_WIDTH;
    localparam int TW = TAG_WIDTH;
    localparam int LW = LINE_WIDTH;
    localparam int BS = BLOCK_SIZE;

    logic          clkIn = 1'b0;
    logic          resetNIn;
    logic          missIn;
    logic [AW-1:0] missAddrIn;
    logic          busy;
    logic          ramReq;
    logic          ramGrant;
    logic [AW-1:0] ramAddr;
    logic [7:0]    ramDataIn;
    logic          fillValid;
    logic [TW-1:0] fillAddr;
    logic [LW-1:0] fillData;

    always #5 clkIn = ~clkIn;

    icache_refill dut (
        .clkIn      (clkIn),
        .resetNIn   (resetNIn),
        .missIn     (missIn),
        .missAddrIn (missAddrIn),
        .busy       (busy),
        .ramReq     (ramReq),
        .ramGrant   (ramGrant),
        .ramAddr    (ramAddr),
        .ramDataIn  (ramDataIn),
        .fillValid  (fillValid),
        .fillAddr   (fillAddr),
        .fillData   (fillData)
    );

    logic [7:0] ram [0:(1<<AW)-1];

    always @(posedge clkIn) ramDataIn <= ram[ramAddr];

    property grantHeld;
        @(posedge clkIn) disable iff (!resetNIn)
            (ramReq && ramGrant) |=> (!ramReq || ramGrant);
    endproperty
    assert property (grantHeld) else $error("FAIL grantHeld: ramGrant dropped during a refill");

    int total = 0;
    int bad = 0;
    logic [LW-1:0] lastFill;
    logic [TW-1:0] lastFillAddr;

    typedef struct {
        logic [AW-1:0] addr;
        int            gntDelay;
        int            pulseAt;
        int            expLat;
        logic [TW-1:0] expTag;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] modelLine(input logic [TW-1:0] tag);
        logic [LW-1:0] l;
        for (int k = 0; k < BS; k++) begin
            l[8*k +: 8] = ram[AW'(int'(tag) * BS + k)];
        end
        return l;
    endfunction

    task automatic checkAllZero(input string name);
        check({name, ".busy"},      128'(busy),      128'(0));
        check({name, ".ramReq"},    128'(ramReq),    128'(0));
        check({name, ".ramAddr"},   128'(ramAddr),   128'(0));
        check({name, ".fillValid"}, 128'(fillValid), 128'(0));
        check({name, ".fillAddr"},  128'(fillAddr),  128'(0));
        check({name, ".fillData"},  128'(fillData),  128'(0));
    endtask

    // One refill: the request is accepted at the edge after it is driven,
    // cycle c counts clocks after acceptance. Grant arrives after d cycles.
    task automatic runRefill(input logic [AW-1:0] addr, input int d, input int pulseAt,
                             input int expLat, input logic [TW-1:0] expTag);
        int fillAt, fills, readStart, idx;
        logic [AW-1:0] expAddr;
        logic [LW-1:0] expLine;
        expLine = modelLine(expTag);
        @(negedge clkIn);
        missIn = 1'b1; missAddrIn = addr; ramGrant = 1'b0;
        @(negedge clkIn);
        missAddrIn = AW'($urandom);
        fillAt = 0; fills = 0; readStart = d + 2;
        for (int c = 1; c <= expLat + 1; c++) begin
            if (c == pulseAt) begin
                missIn = 1'b1; missAddrIn = AW'(17'h00040);
            end else begin
                missIn = 1'b0;
            end
            ramGrant = (c > d);
            if (c < readStart || c > readStart + BS) begin
                expAddr = '0;
            end else begin
                idx = c - readStart;
                if (idx > BS - 1) idx = BS - 1;
                expAddr = AW'(int'(expTag) * BS + idx);
            end
            check("ramAddr", 128'(ramAddr), 128'(expAddr));
            check("ramReq",  128'(ramReq),  128'(c <= readStart + BS));
            check("busy",    128'(busy),    128'(c <= readStart + BS + 1));
            if (fillValid) begin
                fills++;
                if (fillAt == 0) fillAt = c;
                lastFill = fillData;
                lastFillAddr = fillAddr;
                check("fillAddr", 128'(fillAddr), 128'(expTag));
                check("fillData", 128'(fillData), 128'(expLine));
            end
            @(negedge clkIn);
        end
        missIn = 1'b0;
        check("fillLatency", 128'(fillAt), 128'(expLat));
        check("fillCount",   128'(fills),  128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fills, seenAt, fillCyc [2];
        logic [TW-1:0] fillTag [2];
        logic [LW-1:0] fillLine [2];
        logic found;
        logic [AW-1:0] ra;
        int rd;

        for (int a = 0; a < (1 << AW); a++) ram[a] = 8'($urandom);
        for (int k = 0; k < BS; k++) ram[AW'(32'h100 + k)] = 8'(8'hA0 + k);

        vecs[0] = '{addr: 17'h0010C, gntDelay: 0, pulseAt: 0,  expLat: 19, expTag: 13'h0010};
        vecs[1] = '{addr: 17'h0010C, gntDelay: 5, pulseAt: 0,  expLat: 24, expTag: 13'h0010};
        vecs[2] = '{addr: 17'h0010C, gntDelay: 0, pulseAt: 6,  expLat: 19, expTag: 13'h0010};
        vecs[3] = '{addr: 17'h1FFF0, gntDelay: 0, pulseAt: 0,  expLat: 19, expTag: 13'h1FFF};
        vecs[4] = '{addr: 17'h0004F, gntDelay: 2, pulseAt: 0,  expLat: 21, expTag: 13'h0004};
        vecs[5] = '{addr: 17'h1234A, gntDelay: 1, pulseAt: 10, expLat: 20, expTag: 13'h1234};

        resetNIn = 1'b0; missIn = 1'b0; missAddrIn = '0; ramGrant = 1'b0;
        repeat (2) @(negedge clkIn);
        checkAllZero("resetState");
        resetNIn = 1'b1;

        // Reset held for 3 cycles in the middle of READ.
        @(negedge clkIn);
        missIn = 1'b1; missAddrIn = 17'h0010C; ramGrant = 1'b1;
        @(negedge clkIn);
        missIn = 1'b0;
        repeat (7) @(negedge clkIn);
        check("busyBeforeReset", 128'(busy), 128'(1));
        resetNIn = 1'b0;
        #1;
        checkAllZero("resetMidRead");
        repeat (3) begin
            @(negedge clkIn);
            checkAllZero("resetHeld");
        end
        resetNIn = 1'b1;
        runRefill(17'h0010C, 0, 0, 19, 13'h0010);

        for (int i = 0; i < 6; i++) begin
            runRefill(vecs[i].addr, vecs[i].gntDelay, vecs[i].pulseAt, vecs[i].expLat, vecs[i].expTag);
            if (i == 0) begin
                check("basicLine", 128'(lastFill), 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
                check("basicTag",  128'(lastFillAddr), 128'(13'h0010));
            end
        end

        // Back-to-back misses with missIn held high throughout.
        @(negedge clkIn);
        missIn = 1'b1; missAddrIn = 17'h1FFF0; ramGrant = 1'b1;
        @(negedge clkIn);
        fills = 0;
        for (int c = 1; c <= 41; c++) begin
            if (fillValid) begin
                if (fills < 2) begin
                    fillCyc[fills] = c; fillTag[fills] = fillAddr; fillLine[fills] = fillData;
                end
                fills++;
            end
            if (c == 20) check("b2bIdleGap", 128'(busy), 128'(0));
            if (c == 19) missAddrIn = 17'h00020;
            if (c == 39) missIn = 1'b0;
            @(negedge clkIn);
        end
        check("b2bCount", 128'(fills), 128'(2));
        if (fills >= 2) begin
            check("b2bFirstCycle",  128'(fillCyc[0]),  128'(19));
            check("b2bFirstTag",    128'(fillTag[0]),  128'(13'h1FFF));
            check("b2bFirstLine",   128'(fillLine[0]), 128'(modelLine(13'h1FFF)));
            check("b2bSecondCycle", 128'(fillCyc[1]),  128'(39));
            check("b2bSecondTag",   128'(fillTag[1]),  128'(13'h0002));
            check("b2bSecondLine",  128'(fillLine[1]), 128'(modelLine(13'h0002)));
        end

        // Reset asserted during the DONE cycle.
        @(negedge clkIn);
        missIn = 1'b1; missAddrIn = 17'h00200; ramGrant = 1'b1;
        @(negedge clkIn);
        missIn = 1'b0;
        found = 1'b0; seenAt = 0;
        for (int c = 1; c <= 40 && !found; c++) begin
            if (fillValid) begin
                found = 1'b1; seenAt = c;
            end else begin
                @(negedge clkIn);
            end
        end
        check("doneReached", 128'(found), 128'(1));
        check("doneCycle",   128'(seenAt), 128'(19));
        resetNIn = 1'b0;
        #1;
        checkAllZero("resetInDone");
        @(negedge clkIn);
        resetNIn = 1'b1;
        fills = 0;
        repeat (25) begin
            @(negedge clkIn);
            if (fillValid) fills++;
        end
        check("noStaleFill", 128'(fills), 128'(0));

        // Randomized misses against the line/latency model.
        for (int i = 0; i < 10; i++) begin
            ra = AW'($urandom);
            rd = int'($urandom_range(0, 6));
            for (int k = 0; k < BS; k++) ram[AW'(int'(ra) / BS * BS + k)] = 8'($urandom);
            runRefill(ra, rd, ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 18)) : 0,
                      19 + rd, TW'(int'(ra) / BS));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
